// File: rtl/kgp_fetch_unit.sv
// Instruction fetch stage for KGP_MiniRISC: PC, single-outstanding imem requests, decoded fields.
// Optional performance counters (fetch_count, flush_count) are built when FETCH_PERF_EN is defined.
module kgp_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        dec_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_in,
    output logic [3:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  shamt,
    output logic [10:0] funct,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_in_q, pc_in_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_in_d    = pc_in_q;
        valid_d    = valid_q;
        misalign_d = redirect_en && (redirect_pc[1:0] != 2'b00);

        if (redirect_en) begin
            // A redirect wins over everything; an in-flight response must still be drained.
            pc_d = {redirect_pc[31:2], 2'b00};
            unique case (state_q)
                S_FETCH: state_d = S_DRAIN;
                S_WAIT:  state_d = imem_valid ? S_FETCH : S_DRAIN;
                S_HOLD: begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
                S_DRAIN: state_d = imem_valid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        instr_d = imem_rdata;
                        pc_in_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (dec_ready) begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_valid) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_in_q    <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_in_q    <= pc_in_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // The reset state is FETCH, so the request is gated until reset is released.
    assign imem_req     = rst && (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = valid_q;
    assign instr        = instr_q;
    assign pc_in        = pc_in_q;
    assign opcode       = instr_q[31:28];
    assign rs           = instr_q[25:21];
    assign rt           = instr_q[20:16];
    assign shamt        = instr_q[15:11];
    assign funct        = instr_q[10:0];
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    logic        handshake;
    logic        flush;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    assign handshake = (state_q == S_HOLD) && dec_ready && !redirect_en;
    assign flush     = redirect_en && (state_q != S_DRAIN);

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, handshake};
        flush_count_d = flush_count_q + {15'd0, flush};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Self-checking bench for kgp_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a flag-level behavioural model and a variable-latency memory.
module tb_kgp_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [3:0]  opcode;
    logic [4:0]  rs, rt, shamt;
    logic [10:0] funct;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    kgp_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dec_ready(dec_ready), .instr_valid(instr_valid),
        .instr(instr), .pc_in(pc_in), .opcode(opcode),
        .rs(rs), .rt(rt), .shamt(shamt), .funct(funct),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a request is outstanding (m_out) and wanted (m_keep), or an instruction is held (m_vld).
    bit          m_out, m_keep, m_vld, m_mis;
    logic [31:0] m_pc, m_instr, m_pc_in, m_fetch;
    logic [15:0] m_flush;

    // Memory and stimulus knobs.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat_min = 1, lat_max = 1;
    bit          fixed_en = 1'b0, spur_en = 1'b0, rand_mode = 1'b0, late_fire = 1'b0;
    logic [31:0] fixed_data = 32'h1234_5678;
    bit          g_dec = 1'b0, g_redir = 1'b0;
    logic [31:0] g_rpc = '0;
    logic [31:0] addr_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_out = 0; m_keep = 0; m_vld = 0; m_mis = 0;
        m_pc = 32'h0; m_instr = '0; m_pc_in = '0; m_fetch = '0; m_flush = '0;
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = rst && !m_out && !m_vld;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req || !rst) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_vld));
        check("instr", instr, m_instr);
        check("pc_in", pc_in, m_pc_in);
        check("opcode", 32'(opcode), 32'(m_instr[31:28]));
        check("rs", 32'(rs), 32'(m_instr[25:21]));
        check("rt", 32'(rt), 32'(m_instr[20:16]));
        check("shamt", 32'(shamt), 32'(m_instr[15:11]));
        check("funct", 32'(funct), 32'(m_instr[10:0]));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", 32'(flush_count), 32'(m_flush));
`endif
        if (imem_req) addr_q.push_back(imem_addr);
    endtask

    task automatic drive_update();
        bit          req, v;
        logic [31:0] d;
        req = !m_out && !m_vld;
        v   = 1'b0;
        d   = $urandom;
        if (late_fire) begin
            v = 1'b1;
            late_fire = 1'b0;
        end else if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                v = 1'b1; d = mem_data; mem_pend = 1'b0;
            end
        end else if (spur_en && $urandom_range(0, 9) == 0) begin
            v = 1'b1;
        end
        if (req) begin
            mem_pend = 1'b1;
            mem_cnt  = (lat_max > lat_min) ? int'($urandom_range(lat_max, lat_min)) : lat_min;
            mem_data = fixed_en ? fixed_data : $urandom;
        end
        if (rand_mode) begin
            g_dec   = ($urandom_range(0, 9) < 7);
            g_redir = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       g_rpc = $urandom;
                1:       g_rpc = 32'($urandom_range(0, 255)) << 2;
                2:       g_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: g_rpc = $urandom & 32'hFFFF_FFFC;
            endcase
            if (m_out && !m_keep && v) g_redir = 1'b0;
        end
        imem_valid  = v;
        imem_rdata  = d;
        dec_ready   = g_dec;
        redirect_en = g_redir;
        redirect_pc = g_rpc;

        m_mis = g_redir && (g_rpc[1:0] != 2'b00);
        if (g_redir) begin
            m_pc = {g_rpc[31:2], 2'b00};
            if (req) begin
                m_out = 1; m_keep = 0; m_flush++;
            end else if (m_out) begin
                if (m_keep) m_flush++;
                m_keep = 0;
                if (v) m_out = 0;
            end else if (m_vld) begin
                m_vld = 0; m_flush++;
            end
        end else if (req) begin
            m_out = 1; m_keep = 1;
        end else if (m_out) begin
            if (v) begin
                m_out = 0;
                if (m_keep) begin
                    m_vld = 1; m_instr = d; m_pc_in = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_vld && g_dec) begin
            m_vld = 0; m_fetch++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        drive_update();
    endtask

    // Asserts reset asynchronously mid-cycle, holds it over a clock edge, releases at a negedge.
    task automatic do_reset(input bit late);
        #2;
        rst = 1'b0;
        mem_pend = 1'b0;
        imem_valid = 1'b0; redirect_en = 1'b0; dec_ready = 1'b0;
        reset_model();
        #1 compare();
        @(negedge clk);
        compare();
        late_fire = late;
        rst = 1'b1;
        addr_q.delete();
        #1 compare();
        drive_update();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; imem_valid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = '0;

        // Sequential fetch with a 1-cycle memory returning a fixed word.
        fixed_en = 1'b1; g_dec = 1'b1;
        do_reset(1'b0);
        step(); step();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h1);
        check("t1_rs", 32'(rs), 32'h11);
        check("t1_rt", 32'(rt), 32'h14);
        check("t1_shamt", 32'(shamt), 32'h0A);
        check("t1_funct", 32'(funct), 32'h678);
        check("t1_pc_in", pc_in, 32'h0);
        for (int i = 0; i < 7; i++) step();
        check("t1_addr0", addr_q[0], 32'h0);
        check("t1_addr1", addr_q[1], 32'h4);
        check("t1_addr2", addr_q[2], 32'h8);
`ifdef FETCH_PERF_EN
        check("t1_fetch_count", fetch_count, 32'd3);
`endif

        // Decode stall: outputs frozen, no request, then resume at the next PC.
        g_dec = 1'b0;
        do_reset(1'b0);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_valid", 32'(instr_valid), 32'd1);
            check("t2_instr", instr, 32'h1234_5678);
            check("t2_pc_in", pc_in, 32'h0);
            check("t2_no_req", 32'(imem_req), 32'd0);
        end
        g_dec = 1'b1;
        step(); step();
        check("t2_next_addr", imem_addr, 32'h4);
        check("t2_req", 32'(imem_req), 32'd1);

        // Redirect while a 4-cycle fetch is in flight: old data must never appear.
        fixed_en = 1'b0; lat_min = 4; lat_max = 4;
        do_reset(1'b0);
        g_redir = 1'b1; g_rpc = 32'h40;
        step();
        g_redir = 1'b0;
        begin
            int n = 0;
            while (!instr_valid && n < 30) begin
                step();
                n++;
            end
            check("t3_timeout", 32'(instr_valid), 32'd1);
        end
        check("t3_pc_in", pc_in, 32'h40);
        check("t3_addr", addr_q[1], 32'h40);
`ifdef FETCH_PERF_EN
        check("t3_flush_count", 32'(flush_count), 32'd1);
`endif

        // Redirect in HOLD with dec_ready high: the instruction is dropped.
        lat_min = 1; lat_max = 1; g_dec = 1'b0;
        do_reset(1'b0);
        step(); step();
        g_redir = 1'b1; g_rpc = 32'h100; g_dec = 1'b1;
        step();
        g_redir = 1'b0;
        step();
        check("t4_valid", 32'(instr_valid), 32'd0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h100);

        // Misaligned redirect target.
        g_dec = 1'b0;
        do_reset(1'b0);
        step(); step();
        g_redir = 1'b1; g_rpc = 32'h42;
        step();
        g_redir = 1'b0;
        step();
        check("t5_misalign", 32'(misalign_err), 32'd1);
        check("t5_addr", imem_addr, 32'h40);
        step();
        check("t5_misalign_clear", 32'(misalign_err), 32'd0);

        // PC wrap at the top of the address space.
        g_dec = 1'b0;
        do_reset(1'b0);
        step(); step();
        g_redir = 1'b1; g_rpc = 32'hFFFF_FFFC; g_dec = 1'b1;
        step();
        g_redir = 1'b0;
        step();
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(); step(); step();
        check("t6_addr_wrap", imem_addr, 32'h0);
        check("t6_req", 32'(imem_req), 32'd1);

        // Reset during WAIT; a late response lands in the first FETCH after release.
        lat_min = 4; lat_max = 4;
        do_reset(1'b0);
        step();
        lat_min = 1; lat_max = 1;
        do_reset(1'b1);
        step(); step();
        check("t7_valid", 32'(instr_valid), 32'd1);
        check("t7_pc_in", pc_in, 32'h0);
        check("t7_addr", addr_q[0], 32'h0);

        // Randomized traffic with occasional asynchronous resets.
        lat_min = 1; lat_max = 4; spur_en = 1'b1; rand_mode = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset(1'b0);
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
